enemy_health_ctrl: RTL and testbench

Owns the health, type and active state of every on-screen enemy and is the single writer of that state. It arbitrates damage requests from several hit detectors, applies spawns and level clears, reports kills, and serves a registered read port that feeds the per-pixel health bar renderer (`enemy_health`, `enemy_active`, `enemy_type`). It sits between the collision logic and the pixel pipeline.

---
 rtl/game_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/enemy_health_ctrl.sv | 131 +++++++++++++
 tb/tb_enemy_health_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: enemy type/health widths and per-type maximum health.
// The maximum health values match the scaling used by the health bar renderer.
package game_pkg;

    localparam int ENEMY_TYPE_W = 4;
    localparam int HEALTH_W     = 8;

    localparam logic [HEALTH_W-1:0] MAX_HEALTH_T0 = 8'd7;
    localparam logic [HEALTH_W-1:0] MAX_HEALTH_T1 = 8'd3;
    localparam logic [HEALTH_W-1:0] MAX_HEALTH_T2 = 8'd29;
    localparam logic [HEALTH_W-1:0] MAX_HEALTH_T3 = 8'd116;

    // Types outside 0..3 are treated as type 0.
    function automatic logic [ENEMY_TYPE_W-1:0] norm_type(input logic [ENEMY_TYPE_W-1:0] t);
        return (t > 4'd3) ? '0 : t;
    endfunction

    function automatic logic [HEALTH_W-1:0] max_health(input logic [ENEMY_TYPE_W-1:0] t);
        case (norm_type(t))
            4'd1:    return MAX_HEALTH_T1;
            4'd2:    return MAX_HEALTH_T2;
            4'd3:    return MAX_HEALTH_T3;
            default: return MAX_HEALTH_T0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant to the first request at or
// after the pointer; the pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    input  logic         advance
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand_idx;
    logic          found;
    int            cand;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        gnt      = '0;
        gnt_idx  = ptr;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = PW'(cand);
            if (!found && !RST && req[cand_idx]) begin
                found        = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx      = cand_idx;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/enemy_health_ctrl.sv
// Single writer of enemy slot state: arbitrates damage, applies spawns and
// level clears, reports kills and serves a registered read port to the renderer.
module enemy_health_ctrl
    import game_pkg::*;
#(
    parameter  int N_ENEMIES = 8,
    parameter  int N_REQ     = 4,
    localparam int IW        = $clog2(N_ENEMIES)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          dmg_req,
    input  logic [N_REQ*IW-1:0]       dmg_idx,
    input  logic [N_REQ*HEALTH_W-1:0] dmg_amt,
    output logic [N_REQ-1:0]          dmg_gnt,
    input  logic                      spawn_valid,
    input  logic [IW-1:0]             spawn_idx,
    input  logic [ENEMY_TYPE_W-1:0]   spawn_type,
    input  logic                      level_clear,
    input  logic [IW-1:0]             rd_idx,
    output logic [HEALTH_W-1:0]       rd_health,
    output logic [ENEMY_TYPE_W-1:0]   rd_type,
    output logic                      rd_active,
    output logic                      kill_valid,
    output logic [IW-1:0]             kill_idx,
    output logic [ENEMY_TYPE_W-1:0]   kill_type,
    output logic [IW:0]               alive_count
);

    logic [N_ENEMIES-1:0][HEALTH_W-1:0]     health, health_n;
    logic [N_ENEMIES-1:0][ENEMY_TYPE_W-1:0] etype, etype_n;
    logic [N_ENEMIES-1:0]                   active, active_n;

    logic [IW-1:0]           sel_idx;
    logic [HEALTH_W-1:0]     sel_amt;
    logic                    dmg_hit;
    logic [HEALTH_W:0]       diff;
    logic [HEALTH_W-1:0]     new_health;
    logic                    kill_n;
    logic [IW-1:0]           kill_idx_n;
    logic [ENEMY_TYPE_W-1:0] kill_type_n;
    logic [IW:0]             alive_n;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (dmg_req),
        .gnt     (dmg_gnt),
        .advance (dmg_hit)
    );

    assign dmg_hit = |dmg_gnt;

    always_comb begin
        sel_idx = '0;
        sel_amt = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (dmg_gnt[r]) begin
                sel_idx = dmg_idx[r*IW +: IW];
                sel_amt = dmg_amt[r*HEALTH_W +: HEALTH_W];
            end
        end
        // 9-bit subtraction: the borrow bit flags underflow for saturation.
        diff       = {1'b0, health[sel_idx]} - {1'b0, sel_amt};
        new_health = diff[HEALTH_W] ? '0 : diff[HEALTH_W-1:0];
    end

    always_comb begin
        health_n    = health;
        etype_n     = etype;
        active_n    = active;
        kill_n      = 1'b0;
        kill_idx_n  = '0;
        kill_type_n = '0;
        if (level_clear) begin
            health_n = '0;
            active_n = '0;
        end else begin
            if (dmg_hit && active[sel_idx] && sel_amt != '0 &&
                !(spawn_valid && spawn_idx == sel_idx)) begin
                health_n[sel_idx] = new_health;
                if (new_health == '0) begin
                    active_n[sel_idx] = 1'b0;
                    kill_n            = 1'b1;
                    kill_idx_n        = sel_idx;
                    kill_type_n       = etype[sel_idx];
                end
            end
            if (spawn_valid) begin
                health_n[spawn_idx] = max_health(spawn_type);
                etype_n[spawn_idx]  = norm_type(spawn_type);
                active_n[spawn_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        alive_n = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            alive_n = alive_n + {{IW{1'b0}}, active_n[i]};
        end
    end

    // NOTE: slot state is a flop array, not RAM, so it is reset and cleared in one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            health      <= '0;
            etype       <= '0;
            active      <= '0;
            rd_health   <= '0;
            rd_type     <= '0;
            rd_active   <= 1'b0;
            kill_valid  <= 1'b0;
            kill_idx    <= '0;
            kill_type   <= '0;
            alive_count <= '0;
        end else begin
            health      <= health_n;
            etype       <= etype_n;
            active      <= active_n;
            rd_health   <= health[rd_idx];
            rd_type     <= etype[rd_idx];
            rd_active   <= active[rd_idx];
            kill_valid  <= kill_n;
            kill_idx    <= kill_idx_n;
            kill_type   <= kill_type_n;
            alive_count <= alive_n;
        end
    end

endmodule

// File: tb/tb_enemy_health_ctrl.sv
// Self-checking bench for enemy_health_ctrl: directed scenarios plus randomized
// traffic compared against a slot-level behavioural model.
module tb_enemy_health_ctrl;

    localparam int NE = 8;
    localparam int NR = 4;
    localparam int IW = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     dmg_req;
    logic [NR*IW-1:0]  dmg_idx;
    logic [NR*8-1:0]   dmg_amt;
    logic [NR-1:0]     dmg_gnt;
    logic              spawn_valid;
    logic [IW-1:0]     spawn_idx;
    logic [3:0]        spawn_type;
    logic              level_clear;
    logic [IW-1:0]     rd_idx;
    logic [7:0]        rd_health;
    logic [3:0]        rd_type;
    logic              rd_active;
    logic              kill_valid;
    logic [IW-1:0]     kill_idx;
    logic [3:0]        kill_type;
    logic [IW:0]       alive_count;

    int passed = 0;
    int total  = 0;

    // Behavioural model of the slots and the round-robin pointer.
    int m_health[NE];
    int m_type[NE];
    bit m_active[NE];
    int m_ptr;

    logic [NR-1:0] got_gnt, exp_gnt;
    logic [7:0]    exp_rd_health;
    logic [3:0]    exp_rd_type;
    logic          exp_rd_active;
    logic          exp_kill;
    logic [IW-1:0] exp_kill_idx;
    logic [3:0]    exp_kill_type;
    logic [IW:0]   exp_alive;

    enemy_health_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .dmg_req     (dmg_req),
        .dmg_idx     (dmg_idx),
        .dmg_amt     (dmg_amt),
        .dmg_gnt     (dmg_gnt),
        .spawn_valid (spawn_valid),
        .spawn_idx   (spawn_idx),
        .spawn_type  (spawn_type),
        .level_clear (level_clear),
        .rd_idx      (rd_idx),
        .rd_health   (rd_health),
        .rd_type     (rd_type),
        .rd_active   (rd_active),
        .kill_valid  (kill_valid),
        .kill_idx    (kill_idx),
        .kill_type   (kill_type),
        .alive_count (alive_count)
    );

    always #5 CLK = ~CLK;

    function automatic int max_h(input int t);
        case (t)
            1:       return 3;
            2:       return 29;
            3:       return 116;
            default: return 7;
        endcase
    endfunction

    task automatic clear_inputs();
        dmg_req     = '0;
        dmg_idx     = '0;
        dmg_amt     = '0;
        spawn_valid = 1'b0;
        spawn_idx   = '0;
        spawn_type  = '0;
        level_clear = 1'b0;
        rd_idx      = '0;
    endtask

    task automatic set_req(input int r, input int idx, input int amt);
        dmg_req[r]            = 1'b1;
        dmg_idx[r*IW +: IW]   = IW'(idx);
        dmg_amt[r*8 +: 8]     = 8'(amt);
    endtask

    // Samples the grant, advances the model by one clock, then waits for the
    // edge and lands 1 ns after it so registered outputs can be compared.
    task automatic step();
        int g, idx, amt, h, t, cnt;
        #1;
        got_gnt = dmg_gnt;
        if (RST) begin
            exp_gnt = '0;
            for (int i = 0; i < NE; i++) begin
                m_health[i] = 0; m_type[i] = 0; m_active[i] = 1'b0;
            end
            m_ptr = 0;
            exp_rd_health = '0; exp_rd_type = '0; exp_rd_active = 1'b0;
            exp_kill = 1'b0; exp_kill_idx = '0; exp_kill_type = '0;
            exp_alive = '0;
        end else begin
            g = -1;
            for (int i = 0; i < NR; i++) begin
                int r = (m_ptr + i) % NR;
                if (g < 0 && dmg_req[r]) g = r;
            end
            exp_gnt = (g < 0) ? '0 : NR'(1 << g);
            exp_rd_health = 8'(m_health[rd_idx]);
            exp_rd_type   = 4'(m_type[rd_idx]);
            exp_rd_active = m_active[rd_idx];
            exp_kill = 1'b0; exp_kill_idx = '0; exp_kill_type = '0;
            if (g >= 0) m_ptr = (g + 1) % NR;
            if (level_clear) begin
                for (int i = 0; i < NE; i++) begin
                    m_health[i] = 0; m_active[i] = 1'b0;
                end
            end else begin
                if (g >= 0) begin
                    idx = int'(dmg_idx[g*IW +: IW]);
                    amt = int'(dmg_amt[g*8 +: 8]);
                    if (m_active[idx] && amt != 0 && !(spawn_valid && int'(spawn_idx) == idx)) begin
                        h = m_health[idx] - amt;
                        if (h < 0) h = 0;
                        m_health[idx] = h;
                        if (h == 0) begin
                            m_active[idx] = 1'b0;
                            exp_kill      = 1'b1;
                            exp_kill_idx  = IW'(idx);
                            exp_kill_type = 4'(m_type[idx]);
                        end
                    end
                end
                if (spawn_valid) begin
                    t = (spawn_type > 3) ? 0 : int'(spawn_type);
                    m_health[spawn_idx] = max_h(t);
                    m_type[spawn_idx]   = t;
                    m_active[spawn_idx] = 1'b1;
                end
            end
            cnt = 0;
            for (int i = 0; i < NE; i++) cnt += int'(m_active[i]);
            exp_alive = (IW+1)'(cnt);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        dmg_req = '1;
        step();
        step();
        total++;
        if (got_gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", got_gnt);
        else passed++;
        total++;
        if ({rd_health, rd_type, rd_active, kill_valid, kill_idx, kill_type, alive_count} !== '0)
            $display("FAIL reset_outputs got h=%0d t=%0d a=%b kv=%b ki=%0d kt=%0d alive=%0d want all 0",
                     rd_health, rd_type, rd_active, kill_valid, kill_idx, kill_type, alive_count);
        else passed++;
        RST = 1'b0;
        dmg_req = '0;
    endtask

    task automatic test_spawn_read();
        spawn_valid = 1'b1; spawn_idx = 3'd2; spawn_type = 4'd3; rd_idx = 3'd2;
        step();
        total++;
        if (alive_count !== 4'd1 || rd_active !== 1'b0)
            $display("FAIL spawn_rdw got alive=%0d rd_active=%b want alive=1 rd_active=0", alive_count, rd_active);
        else passed++;
        spawn_valid = 1'b0;
        step();
        total++;
        if (rd_health !== 8'd116 || rd_type !== 4'd3 || rd_active !== 1'b1 || rd_health !== exp_rd_health)
            $display("FAIL spawn_read got h=%0d t=%0d a=%b want h=116 t=3 a=1", rd_health, rd_type, rd_active);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < NR; r++) set_req(r, 2, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (got_gnt !== order[k] || got_gnt !== exp_gnt)
                $display("FAIL rr_grant_%0d got %b want %b", k, got_gnt, order[k]);
            else passed++;
        end
        dmg_req = '0;
        step();
        total++;
        if (rd_health !== 8'd111 || rd_health !== exp_rd_health)
            $display("FAIL rr_health got %0d want 111", rd_health);
        else passed++;
    endtask

    task automatic test_kill();
        clear_inputs();
        spawn_valid = 1'b1; spawn_idx = 3'd5; spawn_type = 4'd1; rd_idx = 3'd5;
        step();
        spawn_valid = 1'b0;
        set_req(3, 5, 10);
        step();
        total++;
        if (got_gnt !== 4'b1000) $display("FAIL kill_gnt got %b want 1000", got_gnt);
        else passed++;
        total++;
        if (kill_valid !== 1'b1 || kill_idx !== 3'd5 || kill_type !== 4'd1)
            $display("FAIL kill_report got kv=%b idx=%0d type=%0d want kv=1 idx=5 type=1", kill_valid, kill_idx, kill_type);
        else passed++;
        dmg_req = '0;
        step();
        total++;
        if (kill_valid !== 1'b0 || rd_health !== 8'd0 || rd_active !== 1'b0)
            $display("FAIL kill_after got kv=%b h=%0d a=%b want kv=0 h=0 a=0", kill_valid, rd_health, rd_active);
        else passed++;
        set_req(0, 5, 4);
        step();
        total++;
        if (got_gnt !== 4'b0001 || kill_valid !== 1'b0)
            $display("FAIL kill_dead_hit got gnt=%b kv=%b want gnt=0001 kv=0", got_gnt, kill_valid);
        else passed++;
        dmg_req = '0;
    endtask

    task automatic test_spawn_dmg_same();
        clear_inputs();
        spawn_valid = 1'b1; spawn_idx = 3'd4; spawn_type = 4'd2;
        set_req(1, 4, 5);
        step();
        total++;
        if (got_gnt !== 4'b0010 || kill_valid !== 1'b0)
            $display("FAIL same_slot got gnt=%b kv=%b want gnt=0010 kv=0", got_gnt, kill_valid);
        else passed++;
        clear_inputs();
        rd_idx = 3'd4;
        step();
        total++;
        if (rd_health !== 8'd29 || rd_active !== 1'b1)
            $display("FAIL same_slot_read got h=%0d a=%b want h=29 a=1", rd_health, rd_active);
        else passed++;
    endtask

    task automatic test_level_clear();
        clear_inputs();
        spawn_valid = 1'b1; spawn_idx = 3'd6; spawn_type = 4'd9;
        step();
        total++;
        if (alive_count !== 4'd3) $display("FAIL clear_pre_alive got %0d want 3", alive_count);
        else passed++;
        spawn_valid = 1'b0; rd_idx = 3'd6;
        step();
        total++;
        if (rd_type !== 4'd0 || rd_health !== 8'd7)
            $display("FAIL type_norm got t=%0d h=%0d want t=0 h=7", rd_type, rd_health);
        else passed++;
        level_clear = 1'b1;
        spawn_valid = 1'b1; spawn_idx = 3'd1; spawn_type = 4'd3;
        set_req(2, 6, 200);
        step();
        total++;
        if (got_gnt !== 4'b0100 || kill_valid !== 1'b0 || alive_count !== 4'd0)
            $display("FAIL level_clear got gnt=%b kv=%b alive=%0d want gnt=0100 kv=0 alive=0",
                     got_gnt, kill_valid, alive_count);
        else passed++;
        clear_inputs();
        rd_idx = 3'd1;
        step();
        total++;
        if (rd_active !== 1'b0 || rd_health !== 8'd0)
            $display("FAIL clear_spawn_ignored got a=%b h=%0d want a=0 h=0", rd_active, rd_health);
        else passed++;
        rd_idx = 3'd2;
        step();
        total++;
        if (rd_type !== 4'd3 || rd_health !== 8'd0 || rd_active !== 1'b0)
            $display("FAIL clear_type_kept got t=%0d h=%0d a=%b want t=3 h=0 a=0", rd_type, rd_health, rd_active);
        else passed++;
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        spawn_valid = 1'b1; spawn_idx = 3'd0; spawn_type = 4'd2;
        for (int r = 0; r < NR; r++) set_req(r, 0, 1);
        step();
        spawn_valid = 1'b0;
        step();
        RST = 1'b1;
        step();
        total++;
        if (got_gnt !== 4'b0000) $display("FAIL midreset_gnt got %b want 0000", got_gnt);
        else passed++;
        total++;
        if ({rd_health, rd_type, rd_active, kill_valid, kill_idx, kill_type, alive_count} !== '0)
            $display("FAIL midreset_outputs got h=%0d t=%0d a=%b kv=%b alive=%0d want all 0",
                     rd_health, rd_type, rd_active, kill_valid, alive_count);
        else passed++;
        RST = 1'b0;
        step();
        total++;
        if (got_gnt !== 4'b0001 || got_gnt !== exp_gnt)
            $display("FAIL midreset_restart got %b want 0001", got_gnt);
        else passed++;
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = total - passed;
        for (int c = 0; c < 400; c++) begin
            RST         = ($urandom_range(0, 99) == 0);
            dmg_req     = NR'($urandom);
            dmg_idx     = (NR*IW)'($urandom);
            for (int r = 0; r < NR; r++)
                dmg_amt[r*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                                : 8'($urandom_range(0, 20));
            spawn_valid = ($urandom_range(0, 4) == 0);
            spawn_idx   = IW'($urandom);
            spawn_type  = 4'($urandom);
            level_clear = ($urandom_range(0, 39) == 0);
            rd_idx      = IW'($urandom);
            step();
            total++;
            if (got_gnt !== exp_gnt) $display("FAIL rand_gnt c=%0d got %b want %b", c, got_gnt, exp_gnt);
            else passed++;
            total++;
            if (rd_health !== exp_rd_health || rd_type !== exp_rd_type || rd_active !== exp_rd_active)
                $display("FAIL rand_read c=%0d got h=%0d t=%0d a=%b want h=%0d t=%0d a=%b",
                         c, rd_health, rd_type, rd_active, exp_rd_health, exp_rd_type, exp_rd_active);
            else passed++;
            total++;
            if (kill_valid !== exp_kill || (exp_kill && (kill_idx !== exp_kill_idx || kill_type !== exp_kill_type)))
                $display("FAIL rand_kill c=%0d got kv=%b idx=%0d t=%0d want kv=%b idx=%0d t=%0d",
                         c, kill_valid, kill_idx, kill_type, exp_kill, exp_kill_idx, exp_kill_type);
            else passed++;
            total++;
            if (alive_count !== exp_alive) $display("FAIL rand_alive c=%0d got %0d want %0d", c, alive_count, exp_alive);
            else passed++;
        end
        RST = 1'b0;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_spawn_read();
        test_round_robin();
        test_kill();
        test_spawn_dmg_same();
        test_level_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
